dds_param_regs: RTL and testbench

DDS_PARAM_REGS -- requirements
Module: dds_param_regs

---
 rtl/dds_param_regs.sv | 183 ++++++++++++++++++
 tb/tb_dds_param_regs.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_param_regs.sv
// dds_param_regs: frame-based register file that sets the DDS parameters from UART-decoded address/payload bytes.
// Latency: a committed frame updates its target and pulses param_update two edges after data_done is sampled.
// Backpressure: none. Inputs are strobes accepted every cycle; strobes that arrive during CHECK are dropped.
//
// Ports:
//   sys_clk, sys_rst_n                       : clock, async active-high reset
//   addr_data/_valid, cmd_data/_valid        : address and payload byte strobes
//   data_done                                : end-of-frame strobe
//   freq_word, phase_word, amp_word,
//   wave_sel, dds_en                         : DDS parameter outputs
//   param_update, frame_err, err_cnt         : commit pulse, error pulse, saturating error count
module dds_param_regs #(
  parameter int unsigned TIMEOUT_CYC = 500_000,
  parameter logic [9:0]  AMP_RST     = 10'h3FF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  addr_data,
  input  logic        addr_data_valid,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_data_valid,
  input  logic        data_done,
  output logic [31:0] freq_word,
  output logic [11:0] phase_word,
  output logic [9:0]  amp_word,
  output logic [1:0]  wave_sel,
  output logic        dds_en,
  output logic        param_update,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_PAYLOAD, ST_CHECK} state_t;

  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          r_state;
  logic [7:0]      r_addr;
  logic [31:0]     r_stage;
  logic [2:0]      r_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_commit_pend;
  logic [31:0]     r_freq;
  logic [11:0]     r_phase;
  logic [9:0]      r_amp;
  logic [1:0]      r_wave;
  logic            r_en;
  logic            r_param_update;
  logic            r_frame_err;
  logic [7:0]      r_err_cnt;

  logic [2:0]      w_req_len;
  logic            w_len_ok;
  logic            w_open;
  logic            w_strobe;
  logic            w_timeout;
  logic            w_err;

  // Required payload length per address; zero marks an unmapped address.
  always_comb begin
    w_req_len = 3'd0;
    case (r_addr)
      8'h01:   w_req_len = 3'd4;
      8'h02:   w_req_len = 3'd2;
      8'h03:   w_req_len = 3'd2;
      8'h04:   w_req_len = 3'd1;
      8'h05:   w_req_len = 3'd1;
      default: w_req_len = 3'd0;
    endcase
  end

  assign w_len_ok  = (w_req_len != 3'd0) && (r_cnt == w_req_len);
  assign w_open    = (r_state == ST_ADDR) || (r_state == ST_PAYLOAD);
  assign w_strobe  = addr_data_valid || cmd_data_valid || data_done;
  assign w_timeout = w_open && !w_strobe && (r_to_cnt == TO_LAST);

  // Every error source funnels into one pulse so err_cnt counts pulses, not causes.
  assign w_err = ((r_state == ST_IDLE) && (cmd_data_valid || data_done)) ||
                 (w_open && addr_data_valid) ||
                 w_timeout ||
                 ((r_state == ST_CHECK) && !w_len_ok);

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      r_state        <= ST_IDLE;
      r_addr         <= 8'h00;
      r_stage        <= 32'h0;
      r_cnt          <= 3'd0;
      r_to_cnt       <= '0;
      r_commit_pend  <= 1'b0;
      r_freq         <= 32'h0;
      r_phase        <= 12'h0;
      r_amp          <= AMP_RST;
      r_wave         <= 2'd0;
      r_en           <= 1'b0;
      r_param_update <= 1'b0;
      r_frame_err    <= 1'b0;
      r_err_cnt      <= 8'h00;
    end else begin
      r_commit_pend  <= 1'b0;
      r_param_update <= 1'b0;
      r_frame_err    <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      // Commit runs the cycle after CHECK. r_addr/r_stage cannot change
      // between CHECK and here, so a new frame opening this same edge is safe.
      if (r_commit_pend) begin
        r_param_update <= 1'b1;
        case (r_addr)
          8'h01:   r_freq  <= r_stage;
          8'h02:   r_phase <= r_stage[11:0];
          8'h03:   r_amp   <= r_stage[9:0];
          8'h04:   r_wave  <= r_stage[1:0];
          default: r_en    <= r_stage[0];
        endcase
      end

      case (r_state)
        ST_IDLE: begin
          r_to_cnt <= '0;
          if (addr_data_valid) begin
            r_addr  <= addr_data;
            r_stage <= 32'h0;
            r_cnt   <= 3'd0;
            r_state <= ST_ADDR;
          end
        end

        ST_ADDR, ST_PAYLOAD: begin
          if (addr_data_valid) begin
            // New address restarts the frame; any same-cycle byte is dropped.
            r_addr   <= addr_data;
            r_stage  <= 32'h0;
            r_cnt    <= 3'd0;
            r_to_cnt <= '0;
            r_state  <= ST_ADDR;
          end else begin
            if (cmd_data_valid) begin
              r_stage <= {r_stage[23:0], cmd_data};
              if (r_cnt != 3'd5) begin
                r_cnt <= r_cnt + 3'd1;
              end
              r_state <= ST_PAYLOAD;
            end
            // Placed after the byte shift so a same-cycle byte is still counted.
            if (data_done) begin
              r_state <= ST_CHECK;
            end
            if (w_strobe) begin
              r_to_cnt <= '0;
            end else if (w_timeout) begin
              r_to_cnt <= '0;
              r_state  <= ST_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end

        ST_CHECK: begin
          r_commit_pend <= w_len_ok;
          r_to_cnt      <= '0;
          r_state       <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign freq_word    = r_freq;
  assign phase_word   = r_phase;
  assign amp_word     = r_amp;
  assign wave_sel     = r_wave;
  assign dds_en       = r_en;
  assign param_update = r_param_update;
  assign frame_err    = r_frame_err;
  assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_dds_param_regs.sv
// tb_dds_param_regs: directed frames against dds_param_regs with a queue of expected pulse events.
// Each step pushes the expected pulse (kind, latency, parameter snapshot) and then pops and compares it.
module tb_dds_param_regs;

  localparam int TO = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [7:0]  addr_data = 8'h00;
  logic        addr_data_valid = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_data_valid = 1'b0;
  logic        data_done = 1'b0;
  logic [31:0] freq_word;
  logic [11:0] phase_word;
  logic [9:0]  amp_word;
  logic [1:0]  wave_sel;
  logic        dds_en;
  logic        param_update;
  logic        frame_err;
  logic [7:0]  err_cnt;

  dds_param_regs #(.TIMEOUT_CYC(TO), .AMP_RST(10'h3FF)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .addr_data(addr_data), .addr_data_valid(addr_data_valid),
    .cmd_data(cmd_data), .cmd_data_valid(cmd_data_valid),
    .data_done(data_done),
    .freq_word(freq_word), .phase_word(phase_word), .amp_word(amp_word),
    .wave_sel(wave_sel), .dds_en(dds_en),
    .param_update(param_update), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          commit;
    int          lat;
    logic [31:0] f;
    logic [11:0] p;
    logic [9:0]  a;
    logic [1:0]  w;
    logic        e;
    logic [7:0]  ec;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_freq  = 32'h0;
  logic [11:0] m_phase = 12'h0;
  logic [9:0]  m_amp   = 10'h3FF;
  logic [1:0]  m_wave  = 2'd0;
  logic        m_en    = 1'b0;
  logic [7:0]  m_ec    = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_freq"},  freq_word,  m_freq);
    chk({tag, "_phase"}, {20'h0, phase_word}, {20'h0, m_phase});
    chk({tag, "_amp"},   {22'h0, amp_word},   {22'h0, m_amp});
    chk({tag, "_wave"},  {30'h0, wave_sel},   {30'h0, m_wave});
    chk({tag, "_en"},    {31'h0, dds_en},     {31'h0, m_en});
    chk({tag, "_errcnt"},{24'h0, err_cnt},    {24'h0, m_ec});
  endtask

  function automatic void push_ev(input bit commit, input int lat);
    exp_t x;
    if (!commit) m_ec = (m_ec == 8'hFF) ? 8'hFF : m_ec + 8'd1;
    x.commit = commit; x.lat = lat;
    x.f = m_freq; x.p = m_phase; x.a = m_amp; x.w = m_wave; x.e = m_en; x.ec = m_ec;
    sb.push_back(x);
  endfunction

  // Pops the next expected event and waits (bounded) for the first pulse.
  // n counts negedges from the call; 0 means the pulse is already visible.
  task automatic check_event(input string tag);
    exp_t x;
    int   n;
    bit   seen;
    x = sb.pop_front();
    n = 0;
    seen = 0;
    while (!seen && n <= 40) begin
      if (param_update || frame_err) seen = 1;
      else begin
        @(negedge sys_clk);
        n++;
      end
    end
    chk({tag, "_seen"}, {31'h0, seen}, 32'd1);
    chk({tag, "_lat"}, n, x.lat);
    chk({tag, "_pu"}, {31'h0, param_update}, {31'h0, x.commit});
    chk({tag, "_fe"}, {31'h0, frame_err}, {31'h0, !x.commit});
    chk({tag, "_freq"},  freq_word, x.f);
    chk({tag, "_phase"}, {20'h0, phase_word}, {20'h0, x.p});
    chk({tag, "_amp"},   {22'h0, amp_word},   {22'h0, x.a});
    chk({tag, "_wave"},  {30'h0, wave_sel},   {30'h0, x.w});
    chk({tag, "_en"},    {31'h0, dds_en},     {31'h0, x.e});
    chk({tag, "_errcnt"},{24'h0, err_cnt},    {24'h0, x.ec});
    @(negedge sys_clk);
    chk({tag, "_single"}, {30'h0, param_update, frame_err}, 32'd0);
  endtask

  task automatic strobe_addr(input logic [7:0] a);
    addr_data = a; addr_data_valid = 1'b1;
    @(negedge sys_clk);
    addr_data_valid = 1'b0;
  endtask

  task automatic strobe_cmd(input logic [7:0] d);
    cmd_data = d; cmd_data_valid = 1'b1;
    @(negedge sys_clk);
    cmd_data_valid = 1'b0;
  endtask

  task automatic strobe_done();
    data_done = 1'b1;
    @(negedge sys_clk);
    data_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk_outputs("reset");
    chk("reset_pulses", {30'h0, param_update, frame_err}, 32'd0);

    // Frequency commit
    strobe_addr(8'h01);
    strobe_cmd(8'h12); strobe_cmd(8'h34); strobe_cmd(8'h56); strobe_cmd(8'h78);
    strobe_done();
    m_freq = 32'h12345678; push_ev(1, 2);
    check_event("freq_commit");

    // Short payload
    strobe_addr(8'h02); strobe_cmd(8'h0A); strobe_done();
    push_ev(0, 1);
    check_event("short_payload");

    // Unmapped address
    strobe_addr(8'h07); strobe_cmd(8'h01); strobe_done();
    push_ev(0, 1);
    check_event("bad_addr");

    // Overflow: six bytes to a one-byte register
    strobe_addr(8'h04);
    for (int i = 0; i < 6; i++) strobe_cmd(8'h03);
    strobe_done();
    push_ev(0, 1);
    check_event("overflow");

    // Timeout after one byte
    strobe_addr(8'h03); strobe_cmd(8'h55);
    push_ev(0, TO);
    check_event("timeout");
    // FSM is idle: a stray byte is an immediate error
    strobe_cmd(8'h66);
    push_ev(0, 0);
    check_event("idle_cmd");

    // Restart mid-frame, then enable
    strobe_addr(8'h05);
    strobe_addr(8'h05);
    push_ev(0, 0);
    check_event("restart");
    strobe_cmd(8'h01); strobe_done();
    m_en = 1'b1; push_ev(1, 2);
    check_event("en_commit");

    // Unused stage bits ignored
    strobe_addr(8'h04); strobe_cmd(8'hFE); strobe_done();
    m_wave = 2'd2; push_ev(1, 2);
    check_event("wave_commit");
    strobe_addr(8'h03); strobe_cmd(8'hFC); strobe_cmd(8'h12); strobe_done();
    m_amp = 10'h012; push_ev(1, 2);
    check_event("amp_commit");
    strobe_addr(8'h02); strobe_cmd(8'hAB); strobe_cmd(8'hCD); strobe_done();
    m_phase = 12'hBCD; push_ev(1, 2);
    check_event("phase_commit");

    // Byte and data_done in the same cycle
    strobe_addr(8'h04);
    cmd_data = 8'h01; cmd_data_valid = 1'b1; data_done = 1'b1;
    @(negedge sys_clk);
    cmd_data_valid = 1'b0; data_done = 1'b0;
    m_wave = 2'd1; push_ev(1, 2);
    check_event("cmd_with_done");

    // Asynchronous reset between payload bytes
    strobe_addr(8'h01); strobe_cmd(8'h11);
    #3 sys_rst_n = 1'b1;
    #1;
    m_freq = 32'h0; m_phase = 12'h0; m_amp = 10'h3FF; m_wave = 2'd0; m_en = 1'b0; m_ec = 8'h00;
    sb.delete();
    chk_outputs("async_rst");
    chk("async_rst_pulses", {30'h0, param_update, frame_err}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    strobe_done();
    push_ev(0, 0);
    check_event("done_after_rst");

    // Saturation
    for (int i = 0; i < 300; i++) begin
      strobe_done();
      m_ec = (m_ec == 8'hFF) ? 8'hFF : m_ec + 8'd1;
      if (i == 252) chk("errcnt_fe", {24'h0, err_cnt}, {24'h0, m_ec});
    end
    @(negedge sys_clk);
    chk("errcnt_sat", {24'h0, err_cnt}, {24'h0, m_ec});
    chk_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
